game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//   Frame-rate game controller for the VGA pixel generator. It owns the player box and the four
//   obstacle bars. Each frame it moves the player from the buttons and scrolls the obstacles left.
//   It also detects player/obstacle overlap, counts lives and score, and runs the IDLE/PLAY/HIT/OVER
//   sequence. Outputs feed the pixel generator's box compares and the seven-segment score display.
// PARAMETERS
//   SCREEN_W     640  visible width; obstacle reload x
//   SCREEN_H     480  visible height; player y clamp
//   PLAYER_STEP  4    player y change per frame while a button is held
//   OBS_SPEED    2    obstacle x decrement per frame
//   HIT_FRAMES   60   frames spent in HIT before leaving it
//   LIVES        3    lives loaded at reset and on restart (1..7)
// PORTS
//   clk          in   1   system clock (pixel-tick domain, same as vga_controller)
//   reset        in   1   synchronous, active-low reset
//   frame_tick   in   1   1-cycle pulse per frame, at start of vertical blank
//   btn_up       in   1   debounced, synchronous level
//   btn_down     in   1   debounced, synchronous level
//   btn_start    in   1   debounced, synchronous level
//   player_y     out  10  player top y; box is x 40..90, height 50 (y..y+49)
//   obs_x[0..3]  out  10  each: obstacle left x; width 150, height 30
//                         fixed row tops: 100, 200, 150, 350
//   score_bcd    out  16  4-digit BCD score, saturates at 9999
//   lives        out  3   remaining lives
//   state        out  2   00 IDLE, 01 PLAY, 10 HIT, 11 OVER
// BEHAVIOUR
//   - Reset (reset==0 at a clk edge) sets all outputs: state=IDLE, player_y=200,
//     obs_x={455,400,250,285}, score_bcd=0, lives=LIVES, hit counter=0. Reset overrides everything.
//   - All state updates occur only on clk edges where frame_tick=1. Outputs are registered and
//     visible the next cycle; latency is 1 clk from frame_tick. No change on other cycles.
//   - IDLE: positions held. btn_start=1 at a tick -> PLAY.
//   - PLAY, evaluated at each tick on the current (displayed) register values:
//     * collide = any i where obs_x[i] < 91 && obs_x[i]+150 > 40 (11-bit sum)
//       && row_top[i] < player_y+50 && row_top[i]+30 > player_y.
//     * collide=1 -> state=HIT, lives-=1, hit counter cleared. No movement and no score this tick.
//     * collide=0 -> player moves:
//       - up only: y = max(y-PLAYER_STEP, 0).
//       - down only: y = min(y+PLAYER_STEP, SCREEN_H-50).
//       - both or neither: hold.
//     * collide=0 -> each obstacle moves:
//       - obs_x <= OBS_SPEED: reload to SCREEN_W and score +1 (BCD carry, saturate at 9999).
//       - otherwise obs_x -= OBS_SPEED.
//     * Several wraps in one tick each add 1, i.e. +n.
//   - HIT: positions frozen. The counter increments per tick. The tick on which the count reaches
//     HIT_FRAMES-1 leaves HIT:
//     * lives==0 -> OVER.
//     * otherwise -> PLAY, with player_y=200 and obs_x reloaded to reset values. score_bcd is kept.
//   - OVER: everything frozen. btn_start at a tick -> IDLE with full reset values (score 0,
//     lives=LIVES).
//   - btn_start is ignored in PLAY and HIT. Buttons are ignored outside PLAY.
//   - Reset asserted mid-HIT or mid-PLAY returns to IDLE the next cycle. No partial update.
// TESTING
//   1 reset low 2 clks, release -> state=00, player_y=200, obs_x=455/400/250/285, score=0000,
//     lives=3; 10 ticks without start -> all outputs unchanged.
//   2 start, hold btn_up 60 ticks -> player_y clamps at 0 (not wrapped); hold btn_down 120 ticks
//     -> player_y=430; both held -> unchanged.
//   3 start, no buttons -> obs[2] x=2 after 124 ticks; tick 125 -> obs[2]=640, score=0001.
//     Tick 143 -> obs[3]=640, score=0002.
//   4 continue 3 -> obs[1] x=90 after 155 ticks; tick 156 -> state=HIT, lives=2, positions frozen.
//     After 60 ticks -> PLAY, obs_x reset, player_y=200, score=0002.
//   5 repeat collisions to lives=0 -> OVER after HIT. btn_start -> IDLE, score=0000, lives=3.
//     Preset score 9999 + wrap -> stays 9999.
//   6 reset low during HIT frame 30 -> next cycle IDLE with reset values. frame_tick and
//     btn_start held high during reset -> no effect.

Source files
------------

// File: rtl/game_ctrl.sv
// Frame-rate game controller: moves the player and obstacle bars once per frame,
// detects overlap, and sequences IDLE/PLAY/HIT/OVER with lives and a BCD score.
module game_ctrl #(
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter int          PLAYER_STEP = 4,
    parameter int          OBS_SPEED   = 2,
    parameter int          HIT_FRAMES  = 60,
    parameter int          LIVES       = 3,
    parameter logic [15:0] SCORE_INIT  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_start,
    output logic [9:0]  player_y,
    output logic [9:0]  obs_x [4],
    output logic [15:0] score_bcd,
    output logic [2:0]  lives,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HIT  = 2'b10,
        S_OVER = 2'b11
    } state_t;

    localparam int              HC_W     = $clog2(HIT_FRAMES + 1);
    localparam logic [HC_W-1:0] HIT_LAST = HC_W'(HIT_FRAMES - 2);
    localparam int              Y_MAX    = SCREEN_H - 50;
    localparam logic [9:0]      Y_INIT   = 10'd200;

    state_t          state_r;
    logic [HC_W-1:0] hit_cnt_r;
    logic            collide_s;
    logic [9:0]      y_next_s;
    logic [9:0]      obs_next_s [4];
    logic [2:0]      wrap_cnt_s;
    logic [15:0]     score_next_s;

    function automatic logic [9:0] row_top(input logic [1:0] idx);
        case (idx)
            2'd0:    return 10'd100;
            2'd1:    return 10'd200;
            2'd2:    return 10'd150;
            2'd3:    return 10'd350;
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic [9:0] obs_init(input logic [1:0] idx);
        case (idx)
            2'd0:    return 10'd455;
            2'd1:    return 10'd400;
            2'd2:    return 10'd250;
            2'd3:    return 10'd285;
            default: return 10'd0;
        endcase
    endfunction

    // Single BCD increment that sticks at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        c;
        r = s;
        c = 1'b1;
        if (s == 16'h9999) begin
            return s;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (c) begin
                    if (r[4*d +: 4] == 4'd9) begin
                        r[4*d +: 4] = 4'd0;
                        c = 1'b1;
                    end else begin
                        r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    c = 1'b0;
                end
            end
            return r;
        end
    endfunction

    function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [2:0] n);
        logic [15:0] r;
        r = s;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < n) begin
                r = bcd_inc(r);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Collision test and next-frame positions, all from the currently displayed values.
    always_comb begin
        collide_s  = 1'b0;
        wrap_cnt_s = 3'd0;
        y_next_s   = player_y;
        for (int i = 0; i < 4; i++) begin
            collide_s = collide_s |
                (({1'b0, obs_x[i]} < 11'd91) &&
                 (({1'b0, obs_x[i]} + 11'd150) > 11'd40) &&
                 ({1'b0, row_top(2'(i))} < ({1'b0, player_y} + 11'd50)) &&
                 (({1'b0, row_top(2'(i))} + 11'd30) > {1'b0, player_y}));
            if (obs_x[i] <= 10'(OBS_SPEED)) begin
                obs_next_s[i] = 10'(SCREEN_W);
                wrap_cnt_s    = wrap_cnt_s + 3'd1;
            end else begin
                obs_next_s[i] = obs_x[i] - 10'(OBS_SPEED);
            end
        end
        if (btn_up && !btn_down) begin
            y_next_s = (player_y < 10'(PLAYER_STEP)) ? 10'd0 : player_y - 10'(PLAYER_STEP);
        end else if (btn_down && !btn_up) begin
            y_next_s = (({1'b0, player_y} + 11'(PLAYER_STEP)) > 11'(Y_MAX)) ?
                       10'(Y_MAX) : player_y + 10'(PLAYER_STEP);
        end else begin
            y_next_s = player_y;
        end
        score_next_s = bcd_add(score_bcd, wrap_cnt_s);
    end

    // Game sequencer; every output is a register updated only on frame ticks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            player_y  <= Y_INIT;
            for (int i = 0; i < 4; i++) obs_x[i] <= obs_init(2'(i));
            score_bcd <= SCORE_INIT;
            lives     <= 3'(LIVES);
            hit_cnt_r <= {HC_W{1'b0}};
        end else if (frame_tick) begin
            case (state_r)
                S_IDLE: begin
                    if (btn_start) state_r <= S_PLAY;
                    else           state_r <= S_IDLE;
                end
                S_PLAY: begin
                    if (collide_s) begin
                        state_r   <= S_HIT;
                        lives     <= lives - 3'd1;
                        hit_cnt_r <= {HC_W{1'b0}};
                    end else begin
                        player_y  <= y_next_s;
                        obs_x     <= obs_next_s;
                        score_bcd <= score_next_s;
                    end
                end
                S_HIT: begin
                    // The collision tick itself is the first HIT frame.
                    hit_cnt_r <= hit_cnt_r + {{(HC_W-1){1'b0}}, 1'b1};
                    if (hit_cnt_r == HIT_LAST) begin
                        if (lives == 3'd0) begin
                            state_r <= S_OVER;
                        end else begin
                            state_r  <= S_PLAY;
                            player_y <= Y_INIT;
                            for (int i = 0; i < 4; i++) obs_x[i] <= obs_init(2'(i));
                        end
                    end else begin
                        state_r <= S_HIT;
                    end
                end
                S_OVER: begin
                    if (btn_start) begin
                        state_r   <= S_IDLE;
                        player_y  <= Y_INIT;
                        for (int i = 0; i < 4; i++) obs_x[i] <= obs_init(2'(i));
                        score_bcd <= SCORE_INIT;
                        lives     <= 3'(LIVES);
                        hit_cnt_r <= {HC_W{1'b0}};
                    end else begin
                        state_r <= S_OVER;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign state = state_r;

endmodule
